// File: rtl/fir_filter_pkg.sv
// Shared types and default constants for the multi-channel MAC accumulator (acc_mc).
// Build option ACC_MC_SAT_EN selects saturating accumulators with sticky overflow flags.
package fir_filter_pkg;

  typedef enum logic [1:0] {
    MAC_NOP  = 2'd0,
    MAC_LOAD = 2'd1,
    MAC_ACC  = 2'd2,
    MAC_CLR  = 2'd3
  } mac_op_t;

  localparam int NCH       = 4;
  localparam int DW_DEF    = 16;
  localparam int CW_DEF    = 16;
  localparam int ACCBITS   = 40;
  localparam int OW_DEF    = 16;
  localparam int SHIFT_DEF = 15;

  // Channel index width; a single channel still needs a 1-bit field.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_mc_if.sv
// Transaction and result bus of acc_mc: the master issues MAC ops, the slave returns dump results.
interface acc_mc_if
  import fir_filter_pkg::*;
#(
  parameter int CHW = 2,
  parameter int DW  = DW_DEF,
  parameter int CW  = CW_DEF,
  parameter int OW  = OW_DEF
);

  logic                  in_valid;
  mac_op_t               ctrl_in;
  logic [CHW-1:0]        ch_in;
  logic signed [DW-1:0]  a_in;
  logic signed [CW-1:0]  b_in;
  logic                  dump_in;

  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [OW-1:0]  out_data;
  logic                  ovf_out;

  modport master (
    output in_valid, ctrl_in, ch_in, a_in, b_in, dump_in,
    input  out_valid, out_ch, out_data, ovf_out
  );

  modport slave (
    input  in_valid, ctrl_in, ch_in, a_in, b_in, dump_in,
    output out_valid, out_ch, out_data, ovf_out
  );

endinterface

// File: rtl/acc_round_sat.sv
// Round-half-up arithmetic right shift of an accumulator value, saturated to the OW-bit output range.
module acc_round_sat #(
  parameter int ACCW  = 40,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [ACCW-1:0] acc,
  output logic signed [OW-1:0]   q
);

  // One guard bit keeps the rounding add from overflowing at the positive limit.
  localparam int XW = ACCW + 1;

  // (1 << SHIFT) >> 1 is 2^(SHIFT-1), and collapses to 0 when SHIFT is 0.
  localparam logic signed [XW-1:0] RND   = (XW'(1) << SHIFT) >> 1;
  localparam logic signed [XW-1:0] OUT_MAX = (XW'(1) << (OW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] OUT_MIN = -(XW'(1) << (OW - 1));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shr;

  always_comb begin
    ext = {acc[ACCW-1], acc};
    rnd = ext + RND;
    shr = rnd >>> SHIFT;
    if (shr > OUT_MAX) begin
      q = OUT_MAX[OW-1:0];
    end else if (shr < OUT_MIN) begin
      q = OUT_MIN[OW-1:0];
    end else begin
      q = shr[OW-1:0];
    end
  end

endmodule

// File: rtl/acc_mc.sv
// Multi-channel pipelined multiply-accumulate: stage 1 multiplies, stage 2 updates acc[ch] and dumps.
// Define ACC_MC_SAT_EN for saturating accumulators with sticky per-channel overflow flags.
module acc_mc
  import fir_filter_pkg::*;
#(
  parameter int NCH   = fir_filter_pkg::NCH,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int ACCW  = ACCBITS,
  parameter int OW    = OW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic     clk,
  input  logic     rst,
  acc_mc_if.slave  bus
);

  localparam int CHW  = ch_bits(NCH);
  localparam int CHW1 = CHW + 1;
  localparam int PW   = DW + CW;

  // ---------------- stage 1: multiply and register the op ----------------
  logic                 ch_ok;
  logic                 s1_valid;
  mac_op_t              s1_op;
  logic [CHW-1:0]       s1_ch;
  logic                 s1_dump;
  logic signed [PW-1:0] s1_p;

  // One extra bit lets non-power-of-two NCH reject the unused channel codes.
  assign ch_ok = {1'b0, bus.ch_in} < CHW1'(NCH);

  // NOTE: clocked state is always written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= MAC_NOP;
      s1_ch    <= '0;
      s1_dump  <= 1'b0;
      s1_p     <= '0;
    end else begin
      s1_valid <= bus.in_valid && ch_ok;
      if (bus.in_valid) begin
        s1_op   <= bus.ctrl_in;
        s1_ch   <= bus.ch_in;
        s1_dump <= bus.dump_in;
        s1_p    <= bus.a_in * bus.b_in;
      end
    end
  end

  // ---------------- stage 2: read-modify-write of acc[ch] ----------------
  logic signed [ACCW-1:0] acc [NCH];
  logic signed [ACCW-1:0] cur;
  logic signed [ACCW-1:0] p_ext;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] new_acc;
  logic                   new_ovf;
  logic signed [OW-1:0]   rs_q;

`ifdef ACC_MC_SAT_EN
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic [NCH-1:0] ovf;
  logic           cur_ovf;
  logic           add_ovf;

  assign cur_ovf = ovf[s1_ch];
  // Signed overflow: both operands share a sign that the sum does not.
  assign add_ovf = (cur[ACCW-1] == p_ext[ACCW-1]) && (sum[ACCW-1] != cur[ACCW-1]);
`endif

  assign cur   = acc[s1_ch];
  assign p_ext = ACCW'(s1_p);
  assign sum   = cur + p_ext;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    new_acc = cur;
    new_ovf = 1'b0;
`ifdef ACC_MC_SAT_EN
    new_ovf = cur_ovf;
`endif
    case (s1_op)
      MAC_NOP: begin
        new_acc = cur;
      end
      MAC_LOAD: begin
        new_acc = p_ext;
        new_ovf = 1'b0;
      end
      MAC_ACC: begin
`ifdef ACC_MC_SAT_EN
        if (add_ovf) begin
          new_acc = cur[ACCW-1] ? ACC_MIN : ACC_MAX;
          new_ovf = 1'b1;
        end else begin
          new_acc = sum;
        end
`else
        new_acc = sum;
`endif
      end
      MAC_CLR: begin
        new_acc = '0;
        new_ovf = 1'b0;
      end
      default: begin
        new_acc = cur;
      end
    endcase
  end

  // NOTE: the accumulator array is reset in full because a reset must clear every channel's history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
      end
    end else if (s1_valid) begin
      acc[s1_ch] <= new_acc;
    end
  end

`ifdef ACC_MC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
    end else if (s1_valid) begin
      ovf[s1_ch] <= new_ovf;
    end
  end
`endif

  acc_round_sat #(
    .ACCW  (ACCW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc (new_acc),
    .q   (rs_q)
  );

  // ---------------- result register ----------------
  logic                 out_valid_q;
  logic [CHW-1:0]       out_ch_q;
  logic signed [OW-1:0] out_data_q;
  logic                 ovf_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      out_valid_q <= s1_valid && s1_dump;
      if (s1_valid && s1_dump) begin
        out_ch_q   <= s1_ch;
        out_data_q <= rs_q;
        ovf_out_q  <= new_ovf;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
`ifdef ACC_MC_SAT_EN
  assign bus.ovf_out   = ovf_out_q;
`else
  // Without saturation there is no overflow state to report.
  assign bus.ovf_out   = 1'b0;
`endif

endmodule

// File: tb/tb_acc_mc.sv
// Directed bench for acc_mc: a 4-channel instance for the main scenarios and a 3-channel
// instance whose 2-bit channel field can carry an out-of-range code.
module tb_acc_mc;
  import fir_filter_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  acc_mc_if #(.CHW(2)) bus  ();
  acc_mc_if #(.CHW(2)) bus3 ();

  acc_mc #(.NCH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  acc_mc #(.NCH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Result fields are only meaningful when a result is expected.
  task automatic check_out(input string tag, input bit v, input int ch, input int data, input bit ovf);
    check({tag, ".valid"}, 16'(bus.out_valid), 16'(v));
    if (v) begin
      check({tag, ".ch"},   16'(bus.out_ch),   16'(ch));
      check({tag, ".data"}, bus.out_data,      16'(data));
      check({tag, ".ovf"},  16'(bus.ovf_out),  16'(ovf));
    end
  endtask

  // Inputs change on the falling edge and are held across the next rising edge.
  task automatic issue(input mac_op_t op, input int ch, input int a, input int b, input bit d);
    bus.in_valid = 1'b1;
    bus.ctrl_in  = op;
    bus.ch_in    = 2'(ch);
    bus.a_in     = 16'(a);
    bus.b_in     = 16'(b);
    bus.dump_in  = d;
    @(negedge clk);
  endtask

  // Bubble: other inputs keep their last values, including any dump request.
  task automatic idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue3(input mac_op_t op, input int ch, input int a, input int b, input bit d);
    bus3.in_valid = 1'b1;
    bus3.ctrl_in  = op;
    bus3.ch_in    = 2'(ch);
    bus3.a_in     = 16'(a);
    bus3.b_in     = 16'(b);
    bus3.dump_in  = d;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0; bus.ctrl_in  = MAC_NOP; bus.ch_in  = '0;
    bus.a_in      = '0;   bus.b_in     = '0;      bus.dump_in = 1'b0;
    bus3.in_valid = 1'b0; bus3.ctrl_in = MAC_NOP; bus3.ch_in = '0;
    bus3.a_in     = '0;   bus3.b_in    = '0;      bus3.dump_in = 1'b0;

    // 1. reset for two cycles, then dump the untouched channel 0
    repeat (2) @(negedge clk);
    check_out("rst", 1'b0, 0, 0, 1'b0);
    check("rst.data", bus.out_data, 16'd0);
    check("rst.ovf", 16'(bus.ovf_out), 16'd0);
    rst = 1'b0;
    issue(MAC_NOP, 0, 0, 0, 1'b1);
    idle();
    check_out("nop_dump_ch0", 1'b1, 0, 0, 1'b0);

    // 2. LOAD then back-to-back ACC on ch1: 2*2^28 = 2^29, >>15 -> 16384
    issue(MAC_LOAD, 1, 16384, 16384, 1'b0);
    issue(MAC_ACC, 1, 16384, 16384, 1'b1);
    check_out("acc_ch1_early", 1'b0, 0, 0, 1'b0);
    idle();
    check_out("acc_ch1", 1'b1, 1, 16384, 1'b0);
    idle();
    check_out("acc_ch1_pulse", 1'b0, 0, 0, 1'b0);

    // 3. interleaved channels: +/-32767000 round to +/-1000
    issue(MAC_LOAD, 0, 1000, 32767, 1'b0);
    issue(MAC_LOAD, 2, -1000, 32767, 1'b0);
    issue(MAC_NOP, 0, 0, 0, 1'b1);
    issue(MAC_NOP, 2, 0, 0, 1'b1);
    check_out("ilv_ch0", 1'b1, 0, 1000, 1'b0);
    idle();
    check_out("ilv_ch2", 1'b1, 2, -1000, 1'b0);
    idle();
    check_out("bubble_dump_held_1", 1'b0, 0, 0, 1'b0);
    idle();
    check_out("bubble_dump_held_2", 1'b0, 0, 0, 1'b0);

    // 6. CLR with dump on ch1, then a NOP dump still reads 0
    issue(MAC_CLR, 1, 5, 5, 1'b1);
    issue(MAC_NOP, 1, 0, 0, 1'b1);
    check_out("clr_ch1", 1'b1, 1, 0, 1'b0);
    idle();
    check_out("clr_ch1_nop", 1'b1, 1, 0, 1'b0);

    // 4. (-32768)^2 = 2^30 per op; 200 ops stay in range but the output saturates
    for (int i = 0; i < 200; i++) begin
      issue(MAC_ACC, 3, -32768, -32768, (i == 199));
    end
    idle();
    check_out("sat_200", 1'b1, 3, 32767, 1'b0);
    // 600 ops in total cross 2^39 at op 512
    for (int i = 0; i < 400; i++) begin
      issue(MAC_ACC, 3, -32768, -32768, (i == 399));
    end
    idle();
`ifdef ACC_MC_SAT_EN
    check_out("sat_600", 1'b1, 3, 32767, 1'b1);
`else
    // wrapped to -424*2^30, so the output pins at the negative limit
    check_out("wrap_600", 1'b1, 3, -32768, 1'b0);
`endif
    issue(MAC_LOAD, 3, 1, 1, 1'b1);
    idle();
    check_out("load_clears_ovf", 1'b1, 3, 0, 1'b0);

    // 5a. NCH=3 instance: channel code 3 is dropped without output or side effect
    issue3(MAC_LOAD, 0, 4, 16384, 1'b1);
    issue3(MAC_LOAD, 3, 100, 16384, 1'b1);
    check("nch3_load0.valid", 16'(bus3.out_valid), 16'd1);
    check("nch3_load0.data", bus3.out_data, 16'd2);
    issue3(MAC_NOP, 0, 0, 0, 1'b1);
    check("nch3_drop.valid", 16'(bus3.out_valid), 16'd0);
    bus3.in_valid = 1'b0;
    @(negedge clk);
    check("nch3_ch0_kept.valid", 16'(bus3.out_valid), 16'd1);
    check("nch3_ch0_kept.ch", 16'(bus3.out_ch), 16'd0);
    check("nch3_ch0_kept.data", bus3.out_data, 16'd2);

    // 5b. reset one cycle after a dump input discards it and clears every channel
    issue(MAC_NOP, 1, 0, 0, 1'b1);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("rst_inflight", 1'b0, 0, 0, 1'b0);
    check("rst_inflight.data", bus.out_data, 16'd0);
    rst = 1'b0;
    idle();
    check_out("rst_quiet", 1'b0, 0, 0, 1'b0);
    issue(MAC_ACC, 3, 1, 16384, 1'b1);
    idle();
    check_out("post_rst_ch3", 1'b1, 3, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
